// File: rtl/traffic_light_fsm.sv
// Phase controller for a two-road junction driving an external 4-bit
// phase timer (Clear/Count) and both lamp sets, with flashing-yellow mode.
module traffic_light_fsm #(
   parameter int unsigned T_MAIN_MIN = 8,
   parameter int unsigned T_YEL      = 3,
   parameter int unsigned T_RED      = 2,
   parameter int unsigned T_SIDE_MIN = 4,
   parameter int unsigned T_SIDE_MAX = 12,
   parameter int unsigned T_FLASH    = 4
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Enable,
   input  logic       Car,
   input  logic [0:3] Q,
   output logic       Clear,
   output logic       Count,
   output logic [2:0] Main_light,
   output logic [2:0] Side_light,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      S_ALL_RED_B  = 3'd0,
      S_MAIN_GREEN = 3'd1,
      S_MAIN_YEL   = 3'd2,
      S_ALL_RED_A  = 3'd3,
      S_SIDE_GREEN = 3'd4,
      S_SIDE_YEL   = 3'd5,
      S_FLASH      = 3'd6
   } state_t;

   localparam logic [4:0] MAIN_LAST  = 5'(T_MAIN_MIN - 1);
   localparam logic [4:0] YEL_LAST   = 5'(T_YEL - 1);
   localparam logic [4:0] RED_LAST   = 5'(T_RED - 1);
   localparam logic [4:0] SMIN_LAST  = 5'(T_SIDE_MIN - 1);
   localparam logic [4:0] SMAX_LAST  = 5'(T_SIDE_MAX - 1);
   localparam logic [4:0] FLASH_LAST = 5'(T_FLASH - 1);

   state_t     state_q, state_d;
   logic       flash_q, flash_d;
   logic       clr, hold;
   logic [4:0] q;

   // Q[0] is the MSB, so the vector maps straight onto a plain number
   assign q = {1'b0, Q};

   always_comb begin
      state_d = state_q;
      flash_d = flash_q;
      clr     = 1'b0;
      hold    = 1'b0;
      if (!Reset_n) begin
         clr     = 1'b1;
         state_d = S_ALL_RED_B;
      end else if (!Enable && state_q != S_FLASH) begin
         clr     = 1'b1;
         state_d = S_FLASH;
         flash_d = 1'b1;
      end else begin
         case (state_q)
            S_ALL_RED_B: if (q == RED_LAST) begin
               clr     = 1'b1;
               state_d = S_MAIN_GREEN;
            end
            S_MAIN_GREEN: if (q >= MAIN_LAST) begin
               if (Car) begin
                  clr     = 1'b1;
                  state_d = S_MAIN_YEL;
               end else begin
                  hold = 1'b1;
               end
            end
            S_MAIN_YEL: if (q == YEL_LAST) begin
               clr     = 1'b1;
               state_d = S_ALL_RED_A;
            end
            S_ALL_RED_A: if (q == RED_LAST) begin
               clr     = 1'b1;
               state_d = S_SIDE_GREEN;
            end
            S_SIDE_GREEN:
               if (q == SMAX_LAST || (!Car && q >= SMIN_LAST)) begin
                  clr     = 1'b1;
                  state_d = S_SIDE_YEL;
               end
            S_SIDE_YEL: if (q == YEL_LAST) begin
               clr     = 1'b1;
               state_d = S_ALL_RED_B;
            end
            S_FLASH: if (Enable) begin
               clr     = 1'b1;
               state_d = S_ALL_RED_B;
            end else if (q == FLASH_LAST) begin
               clr     = 1'b1;
               flash_d = ~flash_q;
            end
            default: begin
               clr     = 1'b1;
               state_d = S_ALL_RED_B;
            end
         endcase
      end
   end

   assign Clear = clr;
   assign Count = ~clr & ~hold;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= S_ALL_RED_B;
         flash_q <= 1'b0;
      end else begin
         state_q <= state_d;
         flash_q <= flash_d;
      end
   end

   always_comb begin
      Main_light = 3'b100;
      Side_light = 3'b100;
      case (state_q)
         S_MAIN_GREEN: Main_light = 3'b001;
         S_MAIN_YEL:   Main_light = 3'b010;
         S_SIDE_GREEN: Side_light = 3'b001;
         S_SIDE_YEL:   Side_light = 3'b010;
         S_FLASH: begin
            Main_light = {1'b0, flash_q, 1'b0};
            Side_light = {1'b0, flash_q, 1'b0};
         end
         default: ;
      endcase
   end

   assign State = state_q;

endmodule
